matrix_4x4_loader: RTL and testbench
====================================

# matrix_4x4_loader

- Upstream feeder for the 4x4 fixed-point multiply stage.
- Accepts a serial stream of 32 W-bit words (matrix A, then matrix B, both column-major) and assembles them into a ping-pong pair of banks.
- Presents one complete bank on the parallel aC1..aC4 / bC1..bC4 bus.
- Holds that bank stable for the multiplier's whole compute pass, because the multiplier reads its operand ports directly on every compute cycle. Meanwhile the other bank is filled from the stream.

## Interface
- W, 12, operand width (fixed-point 12:10), passed through unchanged
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  stream word valid
- s_data  in  W  stream word
- s_last  in  1  marks word 31 of a frame
- s_ready  out  1  stream accept; a word transfers on s_valid && s_ready
- valid_out  out  1  presented bank is complete (to multiplier valid_in)
- ready_in  in  1  multiplier ready_out
- aC1..aC4, bC1..bC4  out  [3:0][W-1:0] each  contents of the presented bank
- frame_err  out  1  one-cycle pulse on a framing error

## Operation
- **Word order:** word index k (0..31) decodes as matrix = k[4] (0 = A, 1 = B), column = k[3:2], row = k[1:0]. Example: k = 6 writes aC2[2] and k = 17 writes bC1[1].
- **Bank state:** each of bank 0 and bank 1 holds its own state, EMPTY, FULL or LOCKED. fill_sel and pres_sel are 1-bit pointers.
- **Fill:**
  - s_ready = (state[fill_sel] == EMPTY).
  - Each accepted word writes the decoded slot of bank fill_sel, then the word counter increments.
  - Accepting word 31 with s_last=1 marks the bank FULL, clears the counter and toggles fill_sel.
- **Framing error:** s_last=1 on k<31, or s_last=0 on k=31.
  - frame_err pulses.
  - The counter clears and the bank stays EMPTY, so the partial frame is discarded.
- **Presenter FSM:**
  - P_IDLE: if state[pres_sel]==FULL, go to P_PRESENT with valid_out<=1.
  - P_PRESENT: on valid_out && ready_in, set state[pres_sel]<=LOCKED and valid_out<=0, then go to P_WAIT_BUSY.
  - P_WAIT_BUSY: go to P_WAIT_IDLE when ready_in==0. ready_in is still high for one cycle after acceptance, by multiplier behaviour.
  - P_WAIT_IDLE: when ready_in==1 (multiplier is back in idle), set state[pres_sel]<=EMPTY, toggle pres_sel and return to P_IDLE.
- **Output mux:** the outputs always show bank pres_sel; they never mux to the fill bank.
- **Same-bank events:** release and fill of the same bank cannot occur in the same cycle, because s_ready is computed from registered state.
- **Simultaneous events:** a fill completing on one bank in the same cycle as a release of the other bank is legal, and both updates apply.

## Timing
- **Reset values:**
  - valid_out=0, frame_err=0.
  - Banks EMPTY with storage zeroed, so all a/b outputs read 0.
  - fill_sel=pres_sel=0, counter=0, FSM in P_IDLE.
  - s_ready=1 from the first cycle after reset.
- **Reset mid-operation:** reset mid-frame or mid-lock drops everything immediately (asynchronous). Partial data is lost and valid_out falls without waiting.
- **Latency:** word 31 accepted at edge N sets the bank FULL at N, and valid_out rises at edge N+1.
- **Frame turnaround:** back-to-back frames need no bubble on the stream while the other bank is EMPTY.
- **Both banks occupied:** s_ready stays low until a release.
- **Operand stability:** a/b outputs are stable from valid_out rising until the release edge in P_WAIT_IDLE.

## Structure
- **Package matrix_pkg holds:**
  - W_DEFAULT = 12 and FXP_MUL = 1024.
  - typedef bank_state_e {EMPTY, FULL, LOCKED}.
  - typedef pres_state_e {P_IDLE, P_PRESENT, P_WAIT_BUSY, P_WAIT_IDLE}.
  - typedef mat4_t = logic [3:0][3:0][W-1:0].
- **Sub-module:** matrix_bank, one instance per bank. It holds the 32-word storage with write enable, write index and data inputs, and outputs A and B as mat4_t. The FSMs and pointers live in the top.

## Test plan
- **Single frame:** stream k→k+1 (A[c][r]=4c+r+1, B = identity 1024) → valid_out rises one edge after word 31; aC2[2]=7, bC1[0]=1024, bC1[1]=0. The multiplier model accepts the bank → outputs are held unchanged until its ready_out returns high.
- **Back-to-back frames, slow consumer:** stream two frames with s_valid held high and the consumer's ready_in held low → after the second frame s_ready=0. Release bank 0 → outputs switch to frame 2 and valid_out rises next edge.
- **Early s_last:** s_last=1 on word 10 → frame_err pulses for exactly one cycle and no valid_out. The following clean 32-word frame is presented correctly.
- **Missing s_last:** s_last=0 on word 31 → frame_err pulses and the bank stays EMPTY.
- **Mid-frame reset:** assert rst during word 20 → outputs read 0, valid_out=0 and s_ready=1. A fresh frame then loads normally.
- **Acceptance cycle:** ready_in high on the acceptance cycle and the following cycle (multiplier artefact) → exactly one acceptance, no re-present of the same bank.

Source files
------------

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and constants for the 4x4 matrix loader
package matrix_pkg;

  localparam int W_DEFAULT = 12;
  localparam int FXP_MUL   = 1024;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    LOCKED
  } bank_state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_PRESENT,
    P_WAIT_BUSY,
    P_WAIT_IDLE
  } pres_state_e;

  // Indexed [column][row]; column 0 drives the xC1 port.
  typedef logic [3:0][3:0][W_DEFAULT-1:0] mat4_t;

endpackage

// File: rtl/matrix_4x4_loader_if.sv
// rtl/matrix_4x4_loader_if.sv - stream input and parallel operand bus of the matrix loader
interface matrix_4x4_loader_if #(
  parameter int W = 12
);

  logic                s_valid;
  logic [W-1:0]        s_data;
  logic                s_last;
  logic                s_ready;
  logic                valid_out;
  logic                ready_in;
  logic                frame_err;
  logic [3:0][W-1:0]   aC1, aC2, aC3, aC4;
  logic [3:0][W-1:0]   bC1, bC2, bC3, bC4;

  modport slave (
    input  s_valid, s_data, s_last, ready_in,
    output s_ready, valid_out, frame_err,
    output aC1, aC2, aC3, aC4, bC1, bC2, bC3, bC4
  );

  modport master (
    output s_valid, s_data, s_last, ready_in,
    input  s_ready, valid_out, frame_err,
    input  aC1, aC2, aC3, aC4, bC1, bC2, bC3, bC4
  );

endinterface

// File: rtl/matrix_bank.sv
// rtl/matrix_bank.sv - 32-word operand bank; word k lands in matrix k[4], column k[3:2], row k[1:0]
module matrix_bank
  import matrix_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [4:0]           idx_i,
  input  logic [W_DEFAULT-1:0] data_i,
  output mat4_t                a_o,
  output mat4_t                b_o
);

  logic [31:0][W_DEFAULT-1:0] mem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[idx_i] <= data_i;
    end
  end

  // Packed layout of mat4_t matches the column-major word order directly.
  assign a_o = mem_q[15:0];
  assign b_o = mem_q[31:16];

endmodule

// File: rtl/matrix_4x4_loader.sv
// rtl/matrix_4x4_loader.sv - ping-pong stream-to-parallel loader feeding the 4x4 multiply stage
module matrix_4x4_loader
  import matrix_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  matrix_4x4_loader_if.slave   bus_io
);

  bank_state_e bank_q [2];
  pres_state_e pstate_q;
  logic        fill_sel_q;
  logic        pres_sel_q;
  logic [4:0]  cnt_q;
  logic        valid_out_q;
  logic        frame_err_q;

  logic        s_ready;
  logic        wr_en;
  logic [W-1:0] wr_data;
  mat4_t       a_mat [2];
  mat4_t       b_mat [2];

  assign s_ready = (bank_q[fill_sel_q] == EMPTY);
  assign wr_en   = bus_io.s_valid && s_ready;
  assign wr_data = bus_io.s_data;

  for (genvar i = 0; i < 2; i++) begin : g_bank
    matrix_bank u_bank (
      .clk    (clk),
      .rst    (rst),
      .we_i   (wr_en && (fill_sel_q == 1'(i))),
      .idx_i  (cnt_q),
      .data_i (wr_data),
      .a_o    (a_mat[i]),
      .b_o    (b_mat[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]   <= EMPTY;
      bank_q[1]   <= EMPTY;
      pstate_q    <= P_IDLE;
      fill_sel_q  <= 1'b0;
      pres_sel_q  <= 1'b0;
      cnt_q       <= 5'd0;
      valid_out_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;

      // A bad frame leaves the bank EMPTY; its stale words get overwritten by the next frame.
      if (wr_en) begin
        if (bus_io.s_last != (cnt_q == 5'd31)) begin
          frame_err_q <= 1'b1;
          cnt_q       <= 5'd0;
        end else if (bus_io.s_last) begin
          bank_q[fill_sel_q] <= FULL;
          cnt_q              <= 5'd0;
          fill_sel_q         <= ~fill_sel_q;
        end else begin
          cnt_q <= cnt_q + 5'd1;
        end
      end

      // Fill only touches an EMPTY bank and the presenter only FULL/LOCKED ones, so writes never collide.
      case (pstate_q)
        P_IDLE: begin
          if (bank_q[pres_sel_q] == FULL) begin
            valid_out_q <= 1'b1;
            pstate_q    <= P_PRESENT;
          end
        end
        P_PRESENT: begin
          if (bus_io.ready_in) begin
            bank_q[pres_sel_q] <= LOCKED;
            valid_out_q        <= 1'b0;
            pstate_q           <= P_WAIT_BUSY;
          end
        end
        P_WAIT_BUSY: begin
          if (!bus_io.ready_in) begin
            pstate_q <= P_WAIT_IDLE;
          end
        end
        P_WAIT_IDLE: begin
          if (bus_io.ready_in) begin
            bank_q[pres_sel_q] <= EMPTY;
            pres_sel_q         <= ~pres_sel_q;
            pstate_q           <= P_IDLE;
          end
        end
        default: pstate_q <= P_IDLE;
      endcase
    end
  end

  assign bus_io.s_ready   = s_ready;
  assign bus_io.valid_out = valid_out_q;
  assign bus_io.frame_err = frame_err_q;

  assign bus_io.aC1 = a_mat[pres_sel_q][0];
  assign bus_io.aC2 = a_mat[pres_sel_q][1];
  assign bus_io.aC3 = a_mat[pres_sel_q][2];
  assign bus_io.aC4 = a_mat[pres_sel_q][3];
  assign bus_io.bC1 = b_mat[pres_sel_q][0];
  assign bus_io.bC2 = b_mat[pres_sel_q][1];
  assign bus_io.bC3 = b_mat[pres_sel_q][2];
  assign bus_io.bC4 = b_mat[pres_sel_q][3];

endmodule

// File: tb/tb_matrix_4x4_loader.sv
// tb/tb_matrix_4x4_loader.sv - directed self-checking bench for matrix_4x4_loader
module tb_matrix_4x4_loader;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  matrix_4x4_loader_if #(.W(12)) bus ();

  matrix_4x4_loader dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         isb;
    logic [1:0] c;
    logic [1:0] r;
    int         exp;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // seed 0: A[c][r] = 4c+r+1 and B = identity 1.0; otherwise word k = k+1+seed
  function automatic int exp_word(input int k, input int seed);
    if (seed != 0) return k + 1 + seed;
    if (k < 16) return k + 1;
    return (((k >> 2) & 3) == (k & 3)) ? 1024 : 0;
  endfunction

  function automatic int get_elem(input bit isb, input logic [1:0] c, input logic [1:0] r);
    logic [3:0][11:0] col;
    case (c)
      2'd0:    col = isb ? bus.bC1 : bus.aC1;
      2'd1:    col = isb ? bus.bC2 : bus.aC2;
      2'd2:    col = isb ? bus.bC3 : bus.aC3;
      default: col = isb ? bus.bC4 : bus.aC4;
    endcase
    return int'(col[r]);
  endfunction

  task automatic send_word(input int d, input logic last);
    int n;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = 12'(d);
    bus.s_last  = last;
    n = 0;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) chk("s_ready_timeout", 0, 1);
    @(posedge clk);
  endtask

  // mode 0: clean frame, 1: s_last on word 10, 2: no s_last on word 31
  task automatic send_frame(input int seed, input int mode, input bit drop);
    for (int k = 0; k < 32; k++) begin
      if (mode == 1) begin
        send_word(exp_word(k, seed), k == 10);
        if (k == 10) break;
      end else if (mode == 2) begin
        send_word(exp_word(k, seed), 1'b0);
      end else begin
        send_word(exp_word(k, seed), k == 31);
      end
    end
    if (drop) #1 bus.s_valid = 1'b0;
  endtask

  task automatic consume(input int hold_exp);
    int n;
    n = 0;
    while (!bus.valid_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.valid_out) chk("valid_timeout", 0, 1);
    @(negedge clk);
    bus.ready_in = 1'b1;
    @(posedge clk);
    #1 chk("accept_drops_valid", int'(bus.valid_out), 0);
    @(posedge clk);
    #1 chk("no_double_accept", int'(bus.valid_out), 0);
    @(negedge clk);
    bus.ready_in = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1 chk("operands_held", get_elem(1'b0, 2'd0, 2'd0), hold_exp);
    end
    @(negedge clk);
    bus.ready_in = 1'b1;
    @(posedge clk);
    #1 bus.ready_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t_a;
    errors = 0;
    checks = 0;
    vt[0] = '{1'b0, 2'd1, 2'd2, 7};
    vt[1] = '{1'b1, 2'd0, 2'd0, 1024};
    vt[2] = '{1'b1, 2'd0, 2'd1, 0};
    vt[3] = '{1'b0, 2'd0, 2'd0, 1};
    vt[4] = '{1'b0, 2'd3, 2'd3, 16};
    vt[5] = '{1'b1, 2'd3, 2'd3, 1024};
    vt[6] = '{1'b1, 2'd2, 2'd1, 0};

    rst = 1'b1;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.s_last   = 1'b0;
    bus.ready_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid_out", int'(bus.valid_out), 0);
    chk("rst_frame_err", int'(bus.frame_err), 0);
    chk("rst_aC2_2", get_elem(1'b0, 2'd1, 2'd2), 0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("rst_s_ready", int'(bus.s_ready), 1);

    // single frame, latency and operand values
    send_frame(0, 0, 1'b1);
    chk("latency_edge_n", int'(bus.valid_out), 0);
    @(posedge clk);
    #1 chk("latency_edge_n1", int'(bus.valid_out), 1);
    for (int i = 0; i < 7; i++)
      chk($sformatf("elem_vec%0d", i), get_elem(vt[i].isb, vt[i].c, vt[i].r), vt[i].exp);
    consume(1);
    chk("pres_switch_to_empty", get_elem(1'b0, 2'd1, 2'd2), 0);
    repeat (3) @(posedge clk);
    #1 chk("no_represent", int'(bus.valid_out), 0);

    // back-to-back frames, stalled consumer
    send_frame(100, 0, 1'b0);
    t_a = $time;
    send_frame(200, 0, 1'b1);
    chk("no_bubble_cycles", int'(($time - 1 - t_a) / 10), 32);
    chk("both_full_s_ready", int'(bus.s_ready), 0);
    chk("both_full_valid", int'(bus.valid_out), 1);
    chk("frame1_presented", get_elem(1'b0, 2'd0, 2'd0), 101);
    consume(101);
    chk("switch_frame2", get_elem(1'b0, 2'd0, 2'd0), 201);
    chk("switch_b_frame2", get_elem(1'b1, 2'd3, 2'd3), 232);
    chk("switch_valid_low", int'(bus.valid_out), 0);
    chk("switch_s_ready", int'(bus.s_ready), 1);
    @(posedge clk);
    #1 chk("switch_valid_next", int'(bus.valid_out), 1);
    consume(201);

    // early s_last
    send_frame(90, 1, 1'b1);
    chk("early_err_pulse", int'(bus.frame_err), 1);
    @(posedge clk);
    #1 chk("early_err_one_cycle", int'(bus.frame_err), 0);
    repeat (2) @(posedge clk);
    #1 chk("early_no_valid", int'(bus.valid_out), 0);
    send_frame(50, 0, 1'b1);
    chk("clean_after_early_lat", int'(bus.valid_out), 0);
    @(posedge clk);
    #1 chk("clean_after_early_valid", int'(bus.valid_out), 1);
    chk("clean_after_early_a", get_elem(1'b0, 2'd0, 2'd0), 51);
    chk("clean_after_early_b", get_elem(1'b1, 2'd3, 2'd3), 82);
    consume(51);

    // missing s_last
    send_frame(60, 2, 1'b1);
    chk("missing_err_pulse", int'(bus.frame_err), 1);
    @(posedge clk);
    #1 chk("missing_err_one_cycle", int'(bus.frame_err), 0);
    repeat (3) @(posedge clk);
    #1 chk("missing_no_valid", int'(bus.valid_out), 0);
    chk("missing_bank_empty", int'(bus.s_ready), 1);

    // reset during word 20 with another bank being presented
    send_frame(30, 0, 1'b1);
    @(posedge clk);
    #1 chk("pre_reset_valid", int'(bus.valid_out), 1);
    for (int k = 0; k < 20; k++) send_word(exp_word(k, 40), 1'b0);
    @(negedge clk);
    bus.s_data = 12'(exp_word(20, 40));
    #2 rst = 1'b1;
    #1 chk("reset_valid_drop", int'(bus.valid_out), 0);
    chk("reset_a_zero", get_elem(1'b0, 2'd0, 2'd0), 0);
    chk("reset_b_zero", get_elem(1'b1, 2'd3, 2'd3), 0);
    chk("reset_s_ready", int'(bus.s_ready), 1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst = 1'b0;
    send_frame(7, 0, 1'b1);
    chk("fresh_lat", int'(bus.valid_out), 0);
    @(posedge clk);
    #1 chk("fresh_valid", int'(bus.valid_out), 1);
    chk("fresh_a", get_elem(1'b0, 2'd0, 2'd0), 8);
    chk("fresh_b", get_elem(1'b1, 2'd1, 2'd2), 7 + 1 + 22);
    consume(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
